ultrasonic_range_ctrl: RTL and testbench
========================================

Name: ultrasonic_range_ctrl

Overview:
- Sequences an HC-SR04-style ultrasonic sensor: issues the trigger pulse, times the echo pulse and converts it to centimetres.
- Publishes each result as a registered 16-bit value, fed straight into the display block's `num` input.
- Runs measurement cycles back-to-back at a fixed repetition period while enabled.
- Flags timeouts and out-of-range echoes so the top level can select what the display shows.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz; must be a multiple of 1000000.
- TRIG_US, 10, trigger pulse width in microseconds.
- TIMEOUT_US, 30000, maximum wait for echo rise after trigger falls.
- PERIOD_MS, 60, minimum time from one trigger rise to the next.
- MAX_CM, 400, saturation distance in cm.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  enable continuous measurement cycles.
- echo  in  1  sensor echo, asynchronous to clk.
- trig  out  1  sensor trigger.
- dist_cm  out  16  last accepted distance in cm (binary).
- dist_valid  out  1  one-cycle pulse when dist_cm updates.
- timeout  out  1  sticky: last cycle saw no echo; cleared on next valid result.
- over_range  out  1  sticky: last echo reached MAX_CM; cleared on next in-range result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: while rst=1 at a clock edge, all of the following take effect at that edge.
  - trig=0, dist_cm=0, dist_valid=0, timeout=0, over_range=0, busy=0.
  - State=IDLE, all counters cleared, synchroniser flops cleared to 0.
  - Reset mid-cycle drops trig on the same edge.
- Echo input: echo passes through a 2-flop synchroniser (echo_s, 2-cycle latency).
  - A rise is echo_s going 0->1 on consecutive cycles; a fall is 1->0.
- Microsecond tick: a prescaler pulses us_tick once every CLK_HZ/1000000 cycles.
  - It restarts from 0 on every state entry.
- Period counter: counts us from trig rise and is independent of echo timing.
- States and transitions:
  - IDLE: trig=0. If run=1, go to TRIG next cycle and start the period counter.
  - TRIG: trig=1 for exactly TRIG_US*CLK_HZ/1000000 cycles, then go to WAIT_RISE. trig returns to 0 on the entry edge.
  - WAIT_RISE:
    - Echo already high on entry is ignored; only a genuine rise counts.
    - On rise: go to MEASURE with cm=0 and sub=0.
    - After TIMEOUT_US us_ticks without a rise: set timeout=1, leave dist_cm unchanged, go to HOLDOFF.
  - MEASURE:
    - Each us_tick increments sub (0..57). At sub=57 it wraps to 0 and cm increments, i.e. cm = floor(echo_us/58).
    - On fall: dist_cm<=cm, dist_valid=1 for one cycle, timeout<=0, over_range<=0, go to HOLDOFF.
    - If cm reaches MAX_CM before the fall: dist_cm<=MAX_CM, over_range<=1, dist_valid=1, go to HOLDOFF.
    - A saturated result does not wait for the fall.
  - HOLDOFF:
    - Wait until the period counter reaches PERIOD_MS*1000 us and echo_s=0.
    - Then go to TRIG if run=1, else IDLE.
    - A stuck-high echo extends HOLDOFF indefinitely with no trigger.
- run deasserted mid-cycle: the current cycle completes and its result is published, then the block enters IDLE. run is sampled only in IDLE and at the HOLDOFF exit.
- Simultaneous events:
  - A rise on the same cycle as the timeout expiry counts as a rise (no timeout).
  - A fall on the same cycle cm reaches MAX_CM is reported as over_range.
- Width rules:
  - Internal us counters must cover max(TIMEOUT_US, PERIOD_MS*1000) without overflow.
  - cm never exceeds MAX_CM; the upper bits of dist_cm are zero-extended.

Optional Feature:
- Macro: ULTRA_AVG4_EN.
- Defined:
  - A 4-entry shift register of accepted in-range results feeds an 18-bit sum.
  - dist_cm = sum>>2, updated with dist_valid on each in-range result.
  - Until 4 results exist, the missing entries are 0.
  - Over-range results bypass averaging (dist_cm=MAX_CM) and are not inserted.
  - Timeouts insert nothing.
  - rst clears all entries.
- Undefined: dist_cm is the raw per-cycle result as above; there is no averaging logic.

Test Plan (CLK_HZ=1000000, TRIG_US=10, TIMEOUT_US=300, PERIOD_MS=2, MAX_CM=20):
- run=1 after reset, echo held 0 -> trig high exactly 10 cycles; timeout=1 about 300 cycles after trig falls; next trig rise 2000 cycles after the first.
- echo high for 580 us after trig -> dist_cm=10, one dist_valid pulse, timeout=0, over_range=0.
- echo high for 2000 us -> dist_valid when cm hits 20, dist_cm=20, over_range=1; next trig only after echo falls and the 2 ms period has elapsed.
- echo already high at WAIT_RISE entry, falls, then rises for 116 us -> dist_cm=2 (the initial high is ignored).
- rst=1 for 1 cycle mid-MEASURE -> all outputs 0 at that edge; new trig follows with run=1.
- ULTRA_AVG4_EN defined, echoes 58/116/174/232 us -> dist_cm sequence 0,0,1,2 (sums 1,3,6,10 >>2).

Source files
------------

// File: rtl/ultrasonic_range_ctrl.sv
// rtl/ultrasonic_range_ctrl.sv - HC-SR04 style trigger/echo sequencer with centimetre conversion
//
// Purpose: issues the sensor trigger pulse, times the echo pulse, converts it to
// centimetres (58 us per cm) and publishes the result at a fixed repetition period
// while run is high.
// Optional feature macro: ULTRA_AVG4_EN (4-entry moving average of in-range results).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   run        in   enable back-to-back measurement cycles
//   echo       in   sensor echo, asynchronous to clk
//   trig       out  sensor trigger
//   dist_cm    out  last accepted distance in cm
//   dist_valid out  one-cycle pulse when dist_cm updates
//   timeout    out  sticky: last cycle saw no echo
//   over_range out  sticky: last echo reached MAX_CM
//   busy       out  high whenever the sequencer is not idle
module ultrasonic_range_ctrl #(
   parameter int CLK_HZ     = 50000000,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int PERIOD_MS  = 60,
   parameter int MAX_CM     = 400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        echo,
   output logic        trig,
   output logic [15:0] dist_cm,
   output logic        dist_valid,
   output logic        timeout,
   output logic        over_range,
   output logic        busy
);
   localparam int CYC_PER_US = CLK_HZ / 1000000;
   localparam int TRIG_CYC   = TRIG_US * CYC_PER_US;
   localparam int PERIOD_US  = PERIOD_MS * 1000;
   localparam int US_MAX     = (TIMEOUT_US > PERIOD_US) ? TIMEOUT_US : PERIOD_US;
   localparam int US_W       = $clog2(US_MAX + 1);
   localparam int PRE_W      = $clog2(CYC_PER_US + 1);
   localparam int TRIG_W     = $clog2(TRIG_CYC + 1);
   localparam int CM_W       = $clog2(MAX_CM + 1);

   localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(CYC_PER_US - 1);
   localparam logic [TRIG_W-1:0] TRIG_LAST   = TRIG_W'(TRIG_CYC - 1);
   localparam logic [US_W-1:0]   TO_LAST     = US_W'(TIMEOUT_US - 1);
   localparam logic [US_W-1:0]   PERIOD_V    = US_W'(PERIOD_US);
   localparam logic [US_W-1:0]   PERIOD_LAST = US_W'(PERIOD_US - 1);
   localparam logic [CM_W-1:0]   MAX_CM_V    = CM_W'(MAX_CM);
   localparam logic [5:0]        SUB_LAST    = 6'd57;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_TRIG      = 3'd1;
   localparam logic [2:0] ST_WAIT_RISE = 3'd2;
   localparam logic [2:0] ST_MEASURE   = 3'd3;
   localparam logic [2:0] ST_HOLDOFF   = 3'd4;

   logic [2:0]        state, state_nx;
   logic              echo_m, echo_s, echo_d;
   logic [PRE_W-1:0]  pre_cnt, per_pre;
   logic [US_W-1:0]   us_cnt, per_cnt;
   logic [TRIG_W-1:0] trig_cnt;
   logic [5:0]        sub;
   logic [CM_W-1:0]   cm, cm_next;
   logic              us_tick, per_tick, rise, fall, sub_wrap, sat, period_done;
   logic              entering, to_expire;

   assign us_tick   = (pre_cnt == PRE_LAST);
   assign per_tick  = (per_pre == PRE_LAST);
   assign rise      = echo_s & ~echo_d;
   assign fall      = ~echo_s & echo_d;
   assign sub_wrap  = us_tick && (sub == SUB_LAST);
   // The fall cycle's own tick is counted so a pulse of N us yields floor(N/58).
   assign cm_next   = sub_wrap ? cm + 1'b1 : cm;
   assign sat       = (cm_next == MAX_CM_V);
   assign to_expire = us_tick && (us_cnt == TO_LAST);
   // Looks one tick ahead so the next trigger rises exactly PERIOD_US after the last one.
   assign period_done = (per_cnt >= PERIOD_V) || (per_tick && per_cnt == PERIOD_LAST);
   assign busy      = (state != ST_IDLE);
   assign entering  = (state_nx != state);

`ifdef ULTRA_AVG4_EN
   logic [2:0][CM_W-1:0] hist;
   logic [17:0]          avg_sum;
   assign avg_sum = 18'(cm_next) + 18'(hist[0]) + 18'(hist[1]) + 18'(hist[2]);
`endif

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:      if (run) state_nx = ST_TRIG;
         ST_TRIG:      if (trig_cnt == TRIG_LAST) state_nx = ST_WAIT_RISE;
         // A rise on the expiry cycle wins over the timeout.
         ST_WAIT_RISE: if (rise) state_nx = ST_MEASURE;
                       else if (to_expire) state_nx = ST_HOLDOFF;
         ST_MEASURE:   if (sat || fall) state_nx = ST_HOLDOFF;
         ST_HOLDOFF:   if (period_done && !echo_s) state_nx = run ? ST_TRIG : ST_IDLE;
         default:      state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         echo_m     <= 1'b0;
         echo_s     <= 1'b0;
         echo_d     <= 1'b0;
         pre_cnt    <= '0;
         per_pre    <= '0;
         us_cnt     <= '0;
         per_cnt    <= '0;
         trig_cnt   <= '0;
         sub        <= '0;
         cm         <= '0;
         trig       <= 1'b0;
         dist_cm    <= '0;
         dist_valid <= 1'b0;
         timeout    <= 1'b0;
         over_range <= 1'b0;
`ifdef ULTRA_AVG4_EN
         hist       <= '0;
`endif
      end else begin
         state      <= state_nx;
         echo_m     <= echo;
         echo_s     <= echo_m;
         echo_d     <= echo_s;
         dist_valid <= 1'b0;
         trig       <= (state_nx == ST_TRIG);

         pre_cnt <= (entering || us_tick) ? '0 : pre_cnt + 1'b1;

         // Period timebase runs from trigger rise, untouched by echo activity.
         if (entering && state_nx == ST_TRIG) begin
            per_pre <= '0;
            per_cnt <= '0;
         end else begin
            per_pre <= per_tick ? '0 : per_pre + 1'b1;
            if (per_tick && per_cnt != PERIOD_V)
               per_cnt <= per_cnt + 1'b1;
         end

         if (entering)
            trig_cnt <= '0;
         else if (state == ST_TRIG)
            trig_cnt <= trig_cnt + 1'b1;

         if (entering)
            us_cnt <= '0;
         else if (state == ST_WAIT_RISE && us_tick)
            us_cnt <= us_cnt + 1'b1;

         if (entering && state_nx == ST_MEASURE) begin
            cm  <= '0;
            sub <= '0;
         end else if (state == ST_MEASURE && us_tick) begin
            sub <= sub_wrap ? 6'd0 : sub + 6'd1;
            cm  <= cm_next;
         end

         if (state == ST_WAIT_RISE && !rise && to_expire)
            timeout <= 1'b1;

         if (state == ST_MEASURE) begin
            if (sat) begin
               dist_cm    <= 16'(MAX_CM_V);
               over_range <= 1'b1;
               timeout    <= 1'b0;
               dist_valid <= 1'b1;
            end else if (fall) begin
`ifdef ULTRA_AVG4_EN
               dist_cm    <= 16'(avg_sum >> 2);
               hist       <= {hist[1:0], cm_next};
`else
               dist_cm    <= 16'(cm_next);
`endif
               over_range <= 1'b0;
               timeout    <= 1'b0;
               dist_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ultrasonic_range_ctrl.sv
// tb/tb_ultrasonic_range_ctrl.sv - scoreboard bench for ultrasonic_range_ctrl
module tb_ultrasonic_range_ctrl;
   localparam int CLK_HZ     = 1000000;
   localparam int TRIG_US    = 10;
   localparam int TIMEOUT_US = 300;
   localparam int PERIOD_MS  = 2;
   localparam int MAX_CM     = 20;
   localparam int PERIOD_CYC = PERIOD_MS * 1000 * (CLK_HZ / 1000000);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        echo = 1'b0;
   logic        trig;
   logic [15:0] dist_cm;
   logic        dist_valid;
   logic        timeout;
   logic        over_range;
   logic        busy;

   ultrasonic_range_ctrl #(
      .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
      .PERIOD_MS(PERIOD_MS), .MAX_CM(MAX_CM)
   ) dut (
      .clk(clk), .rst(rst), .run(run), .echo(echo), .trig(trig),
      .dist_cm(dist_cm), .dist_valid(dist_valid), .timeout(timeout),
      .over_range(over_range), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   typedef struct {
      bit is_to;
      int cm;
      bit over;
      bit to;
   } exp_t;

   exp_t sb[$];

   // Reference model: sticky flags, last published distance, averaging history.
   bit m_to   = 0;
   bit m_over = 0;
   int m_dist = 0;
   int hist[$];

   task automatic expect_result(input bit has_echo, input int len_us);
      exp_t e;
      int   cmv;
      int   sum;
      if (!has_echo) begin
         if (!m_to) begin
            e.is_to = 1; e.cm = m_dist; e.over = m_over; e.to = 1;
            sb.push_back(e);
         end
         m_to = 1;
      end else begin
         cmv = len_us / 58;
         if (cmv >= MAX_CM) begin
            m_dist = MAX_CM;
            m_over = 1;
         end else begin
`ifdef ULTRA_AVG4_EN
            hist.push_front(cmv);
            if (hist.size() > 4) void'(hist.pop_back());
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            m_dist = sum / 4;
`else
            sum = 0;
            m_dist = cmv + sum;
`endif
            m_over = 0;
         end
         m_to = 0;
         e.is_to = 0; e.cm = m_dist; e.over = m_over; e.to = 0;
         sb.push_back(e);
      end
   endtask

   // Monitor: every published result or fresh timeout pops one expectation.
   bit   prev_to = 0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst) begin
         prev_to = 0;
      end else begin
         if (dist_valid || (timeout && !prev_to)) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", int'(dist_valid), int'(timeout));
               chk("unexpected_event_queue", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               chk("event_kind", int'(!dist_valid), int'(mon_e.is_to));
               chk("dist_cm", int'(dist_cm), mon_e.cm);
               chk("over_range", int'(over_range), int'(mon_e.over));
               chk("timeout", int'(timeout), int'(mon_e.to));
            end
         end
         prev_to = timeout;
      end
   end

   int last_rise  = -1;
   bit exact_next = 0;

   // kind 0: no echo, 1: echo pulse after d us, 2: echo high across WAIT_RISE entry
   task automatic do_cycle(input int kind, input int d, input int len, input bit drop_run);
      int  k;
      int  w;
      int  t_rise;
      int  end_rel;
      bit  was_to;
      k = 0;
      while (!trig && k < 6000) begin @(negedge clk); k++; end
      if (!trig) begin
         chk("trig_rise_seen", int'(trig), 1);
         return;
      end
      t_rise = cyc;
      if (last_rise >= 0) begin
         if (exact_next) chk("trig_period", t_rise - last_rise, PERIOD_CYC);
         else            chk("trig_period_min", int'(t_rise - last_rise >= PERIOD_CYC), 1);
      end
      last_rise = t_rise;
      if (drop_run) run = 1'b0;
      if (kind == 2) echo = 1'b1;
      w = 0;
      while (trig && w < 100) begin @(negedge clk); w++; end
      chk("trig_width", w, TRIG_US);
      end_rel = TRIG_US + TIMEOUT_US;
      case (kind)
         0: begin
            was_to = m_to;
            expect_result(0, 0);
            if (!was_to) begin
               k = 0;
               while (!timeout && k < 400) begin @(negedge clk); k++; end
               chk("timeout_latency", k, TIMEOUT_US);
            end
         end
         1: begin
            expect_result(1, len);
            repeat (d) @(negedge clk);
            echo = 1'b1;
            repeat (len) @(negedge clk);
            echo = 1'b0;
            end_rel = TRIG_US + d + len;
         end
         default: begin
            expect_result(1, len);
            repeat (d) @(negedge clk);
            echo = 1'b0;
            repeat (20) @(negedge clk);
            echo = 1'b1;
            repeat (len) @(negedge clk);
            echo = 1'b0;
            end_rel = TRIG_US + d + 20 + len;
         end
      endcase
      exact_next = (end_rel < PERIOD_CYC - 10);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_trig"}, int'(trig), 0);
      chk({tag, "_dist_cm"}, int'(dist_cm), 0);
      chk({tag, "_dist_valid"}, int'(dist_valid), 0);
      chk({tag, "_timeout"}, int'(timeout), 0);
      chk({tag, "_over_range"}, int'(over_range), 0);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      #(10 * 99000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int seen;
      int kind;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      run = 1'b1;

      do_cycle(0, 0, 0, 0);
      do_cycle(1, 30, 580, 0);
      do_cycle(1, 40, 2000, 0);
      do_cycle(2, 50, 116, 0);
      do_cycle(1, 20, 57, 0);
      do_cycle(1, 20, 58, 0);
      do_cycle(1, 25, 1159, 0);
      do_cycle(1, 25, 1160, 0);
      do_cycle(0, 0, 0, 0);
      do_cycle(0, 0, 0, 0);
      do_cycle(1, 10, 300, 0);

      for (int i = 0; i < 10; i++) begin
         kind = $urandom_range(0, 3);
         if (kind == 0)      do_cycle(0, 0, 0, 0);
         else if (kind == 2) do_cycle(2, $urandom_range(1, 100), $urandom_range(20, 1400), 0);
         else                do_cycle(1, $urandom_range(1, 250), $urandom_range(20, 1400), 0);
      end

      // run dropped mid-cycle: result still published, then idle with no trigger.
      do_cycle(1, 30, 350, 1);
      k = 0;
      while (busy && k < 3000) begin @(negedge clk); k++; end
      chk("idle_after_run_low", int'(busy), 0);
      seen = 0;
      repeat (2500) begin
         @(negedge clk);
         if (trig) seen++;
      end
      chk("no_trig_when_stopped", seen, 0);
      run = 1'b1;
      last_rise = -1;

      // Reset in the middle of MEASURE.
      k = 0;
      while (!trig && k < 100) begin @(negedge clk); k++; end
      k = 0;
      while (trig && k < 100) begin @(negedge clk); k++; end
      repeat (20) @(negedge clk);
      echo = 1'b1;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      rst = 1'b0;
      echo = 1'b0;
      sb.delete();
      hist.delete();
      m_to = 0; m_over = 0; m_dist = 0;
      k = 0;
      while (!trig && k < 10) begin @(negedge clk); k++; end
      chk("trig_after_reset_latency", k, 1);
      do_cycle(1, 30, 580, 0);

      k = 0;
      while (sb.size() > 0 && k < 4000) begin @(negedge clk); k++; end
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
